// File: rtl/fp_mac_accum_if.sv
// fp_mac_accum_if: beat input and frame result handshakes for fp_mac_accum.
interface fp_mac_accum_if #(
    parameter int WD = 20,
    parameter int WC = 20,
    parameter int WO = 24
);
    logic in_valid, in_ready, out_valid, out_ready, ovf;
    logic signed [WD-1:0] din;
    logic signed [WC-1:0] coef;
    logic signed [WO-1:0] dout;
    modport master(output in_valid, din, coef, out_ready, input in_ready, out_valid, dout, ovf);
    modport slave(input in_valid, din, coef, out_ready, output in_ready, out_valid, dout, ovf);
endinterface

// File: rtl/fp_mac_accum.sv
// fp_mac_accum: framed fixed-point multiply-accumulate; truncates and saturates or wraps
// the NTAPS-beat sum into Q(WIO).(WFO) with a per-frame overflow flag.
module fp_mac_accum #(
    parameter int WI1 = 4,
    parameter int WF1 = 16,
    parameter int WI2 = 4,
    parameter int WF2 = 16,
    parameter int NTAPS = 8,
    parameter int WIO = 8,
    parameter int WFO = 16,
    parameter int SAT = 1
) (
    input logic clk,
    input logic rst_n,
    fp_mac_accum_if.slave bus
);
    localparam int PW = WI1 + WI2 + WF1 + WF2;
    localparam int AW = PW + $clog2(NTAPS);
    localparam int FA = WF1 + WF2;
    localparam int WO = WIO + WFO;
    localparam int EXT = WFO > FA ? WFO - FA : 0;
    localparam int DROP = FA > WFO ? FA - WFO : 0;
    localparam int SW = AW + EXT;
    localparam int XW = (SW > WO ? SW : WO) + 1;
    localparam int CW = $clog2(NTAPS);
    localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (WO - 1)) - XW'(1);
    localparam logic signed [XW-1:0] MINV = -(XW'(1) <<< (WO - 1));

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count;
    logic signed [PW-1:0] prod;
    logic p_valid;
    logic signed [AW-1:0] acc;
    logic signed [SW-1:0] wide;
    logic signed [XW-1:0] scaled;
    logic signed [WO-1:0] conv;
    logic take, last, done, give, hi, lo;

    assign bus.in_ready = state == IDLE || state == ACC;
    assign bus.out_valid = state == HOLD;
    assign take = bus.in_valid && bus.in_ready;
    assign last = take && count == CW'(NTAPS - 1);
    assign done = state == DRAIN && !p_valid;
    assign give = state == HOLD && bus.out_ready;

    // Arithmetic shift right floors the dropped fraction bits.
    assign wide = SW'(acc) <<< EXT;
    assign scaled = XW'(wide >>> DROP);
    assign hi = scaled > MAXV;
    assign lo = scaled < MINV;
    assign conv = (SAT != 0 && hi) ? MAXV[WO-1:0] : (SAT != 0 && lo) ? MINV[WO-1:0] : scaled[WO-1:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = last ? DRAIN : take ? ACC : done ? HOLD : give ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count <= '0;
            prod <= '0;
            p_valid <= 1'b0;
            acc <= '0;
            bus.dout <= '0;
            bus.ovf <= 1'b0;
        end else begin
            p_valid <= take;
            if (take) begin
                prod <= PW'(bus.din) * PW'(bus.coef);
                count <= last ? '0 : count + CW'(1);
            end
            if (p_valid) acc <= acc + AW'(prod);
            else if (give) acc <= '0;
            if (done) begin
                bus.dout <= conv;
                bus.ovf <= hi || lo;
            end
        end
endmodule
